// File: rtl/uart_stop_frame_check.sv
// Stop-bit and framing checker for the UART receive path: one or two stop bits per frame,
// BREAK detection, and sticky/counted framing-error status for software.
module uart_stop_frame_check #(
   parameter int unsigned CNT_WIDTH = 8,
   parameter bit          BREAK_EN  = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Frame_Start,
   input  logic                 Two_Stop,
   input  logic                 Sampled_bit,
   input  logic                 Stop_EN,
   input  logic                 Data_Zero,
   input  logic                 Err_Clr,
   output logic                 Stop_ERR,
   output logic                 Break_DET,
   output logic                 Frame_Done,
   output logic                 Sticky_ERR,
   output logic [CNT_WIDTH-1:0] Err_Cnt
);

   localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
   localparam logic                 BrkOn  = BREAK_EN;

   typedef enum logic [1:0] {StIdle, StWaitS1, StWaitS2, StReport} state_t;

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic                 s1_q, s1_d;
   logic                 s2_q, s2_d;
   logic                 z_q, z_d;
   logic                 stop_err_q, stop_err_d;
   logic                 break_det_q, break_det_d;
   logic                 sticky_q, sticky_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // fin marks the edge that completes a frame; err/brk are evaluated with the live final
   // stop sample so the status is visible in the same cycle as Frame_Done.
   logic fin, err, brk;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      z_d     = z_q;
      fin     = 1'b0;
      err     = 1'b0;
      brk     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Frame_Start) begin
               mode_d  = Two_Stop;
               state_d = StWaitS1;
            end
         end
         StWaitS1: begin
            if (Frame_Start) begin
               mode_d  = Two_Stop;
               state_d = StWaitS1;
            end else if (Stop_EN) begin
               s1_d = Sampled_bit;
               z_d  = Data_Zero;
               if (mode_q) begin
                  state_d = StWaitS2;
               end else begin
                  state_d = StReport;
                  fin     = 1'b1;
                  err     = ~Sampled_bit;
                  brk     = BrkOn & Data_Zero & ~Sampled_bit;
               end
            end
         end
         StWaitS2: begin
            if (Frame_Start) begin
               mode_d  = Two_Stop;
               state_d = StWaitS1;
            end else if (Stop_EN) begin
               s2_d    = Sampled_bit;
               state_d = StReport;
               fin     = 1'b1;
               err     = ~s1_q | ~Sampled_bit;
               brk     = BrkOn & z_q & ~s1_q & ~Sampled_bit;
            end
         end
         StReport: begin
            if (Frame_Start) begin
               mode_d  = Two_Stop;
               state_d = StWaitS1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stop_err_d  = stop_err_q;
      break_det_d = break_det_q;
      sticky_d    = sticky_q;
      cnt_d       = cnt_q;
      if (Err_Clr) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end
      if (fin) begin
         stop_err_d  = err;
         break_det_d = brk;
         if (err) begin
            sticky_d = 1'b1;
            if (cnt_d != CntMax) cnt_d = cnt_d + CntOne;
         end
      end
      // A clear landing on the report cycle of an errored frame still records that frame.
      if (Err_Clr && (state_q == StReport) && stop_err_q) begin
         sticky_d = 1'b1;
         cnt_d    = CntOne;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         mode_q      <= 1'b0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         z_q         <= 1'b0;
         stop_err_q  <= 1'b0;
         break_det_q <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         z_q         <= z_d;
         stop_err_q  <= stop_err_d;
         break_det_q <= break_det_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
      end
   end

   assign Stop_ERR   = stop_err_q;
   assign Break_DET  = break_det_q;
   assign Frame_Done = (state_q == StReport);
   assign Sticky_ERR = sticky_q;
   assign Err_Cnt    = cnt_q;

endmodule

// File: doc/uart_stop_frame_check.md
Name: uart_stop_frame_check

Overview:
Parametrised stop-bit and framing checker for the UART receive path. It checks one or two stop bits per frame, selectable per frame, and detects line BREAK conditions. It also keeps sticky and counted error status for software. It sits between the bit sampler and the RX FSM and deserializer, and is driven by per-bit enable strobes from the RX FSM.

Parameters:
CNT_WIDTH, 8, width of saturating framing-error counter Err_Cnt
BREAK_EN, 1, 1 = break detection active; 0 = Break_DET tied low, break frames count as plain framing errors

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
Frame_Start  input  1  one-cycle pulse at start-bit acceptance; begins a new frame check
Two_Stop  input  1  stop-bit mode, latched on Frame_Start: 0 = one stop bit, 1 = two stop bits
Sampled_bit  input  1  majority-voted line sample from the sampler
Stop_EN  input  1  one-cycle pulse: Sampled_bit is a stop-bit sample
Data_Zero  input  1  deserializer flag: all data and parity bits received were 0; valid while Stop_EN is high
Err_Clr  input  1  one-cycle pulse: clear Sticky_ERR and Err_Cnt
Stop_ERR  output  1  framing error of the last completed frame; held until next report
Break_DET  output  1  last completed frame was a BREAK; held until next report
Frame_Done  output  1  one-cycle pulse: Stop_ERR and Break_DET updated this cycle
Sticky_ERR  output  1  set by any framing error; cleared only by Err_Clr or RST
Err_Cnt  output  CNT_WIDTH  count of frames with framing error; saturates at all-ones

Behaviour:
- Reset (RST=1 at CLK edge): state IDLE. Stop_ERR, Break_DET, Frame_Done and Sticky_ERR are 0. Err_Cnt is 0. Internal mode, bit and zero latches are 0.
- FSM states: IDLE, WAIT_S1, WAIT_S2, REPORT.
- IDLE: Stop_EN is ignored. On Frame_Start, latch Two_Stop into mode and go to WAIT_S1.
- WAIT_S1: on Stop_EN, latch s1 = Sampled_bit and z = Data_Zero. If mode = 1, go to WAIT_S2; otherwise go to REPORT.
- WAIT_S2: on Stop_EN, latch s2 = Sampled_bit and go to REPORT.
- Frame_Start in WAIT_S1 or WAIT_S2: abort the current frame with no report and no counting. Re-latch Two_Stop and go to WAIT_S1.
- Frame_Start and Stop_EN in the same cycle: Frame_Start wins.
- REPORT (exactly one cycle), then go to IDLE:
  - err = ~s1 | (mode & ~s2).
  - brk = BREAK_EN & z & ~s1 & (~mode | ~s2).
  - Register Stop_ERR <= err and Break_DET <= brk. Frame_Done = 1 for this cycle only.
  - If err: Sticky_ERR <= 1, and Err_Cnt increments unless it is all-ones.
  - Frame_Start in REPORT: the report completes, then the FSM goes to WAIT_S1 instead of IDLE, latching Two_Stop.
- Latency: Frame_Done asserts the cycle after the final Stop_EN. Stop_ERR, Break_DET, Sticky_ERR and Err_Cnt change in that same cycle.
- Err_Clr: clears Sticky_ERR and Err_Cnt in any state.
  - Err_Clr in the REPORT cycle with err = 1: set wins. Sticky_ERR = 1 and Err_Cnt = 1.
  - Err_Clr does not affect Stop_ERR or Break_DET.
- Saturation: Err_Cnt at 2^CNT_WIDTH-1 stays there on further errors and does not wrap.
- RST mid-frame: the frame is discarded, all outputs are 0 on the next cycle, and no Frame_Done is produced.
- Mode is fixed per frame: Two_Stop changes after Frame_Start have no effect until the next Frame_Start.

Test Plan:
1. RST=1 for 2 cycles, then release -> all outputs 0 and Err_Cnt=0. Stop_EN=1 with Sampled_bit=0 while IDLE -> no Frame_Done, outputs stay 0.
2. Two_Stop=0, Frame_Start, then Stop_EN with Sampled_bit=1 -> Frame_Done one cycle later, Stop_ERR=0, Err_Cnt=0. Repeat with Sampled_bit=0, Data_Zero=0 -> Stop_ERR=1, Break_DET=0, Sticky_ERR=1, Err_Cnt=1.
3. Two_Stop=1, stop samples 1 then 0 -> Frame_Done one cycle after the second Stop_EN, Stop_ERR=1. Stop samples 1,1 -> Stop_ERR=0 and Sticky_ERR still 1.
4. Data_Zero=1 with stop sample 0 (BREAK_EN=1) -> Break_DET=1, Stop_ERR=1. Same stimulus with BREAK_EN=0 -> Break_DET=0, Stop_ERR=1.
5. CNT_WIDTH=2, five error frames -> Err_Cnt sequence 1,2,3,3,3. Err_Clr in the REPORT cycle of a sixth error frame -> Err_Cnt=1, Sticky_ERR=1. Lone Err_Clr afterwards -> Err_Cnt=0, Sticky_ERR=0.
6. Two_Stop=1, first stop sample 1, then Frame_Start before the second Stop_EN -> no Frame_Done and Err_Cnt unchanged; the new frame (Two_Stop=0, stop sample 1) reports Stop_ERR=0. RST mid-WAIT_S2 -> no Frame_Done, outputs 0.
